// File: rtl/alu_operand_entry.sv
// rtl/alu_operand_entry.sv - debounced button entry of ALU operands with a valid/ready issue port
module alu_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_op,
  input  logic       btn_go,
  output logic       operand_a,
  output logic       operand_b,
  output logic [1:0] option,
  output logic       issue_valid,
  input  logic       issue_ready,
  output logic [7:0] issue_count,
  output logic       busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ENTRY = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t state;

  // Bit order shared by all per-button vectors: {go, op, b, a}
  logic [3:0]    btn_raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    level;
  logic [3:0]    level_d;
  logic [3:0]    press;
  logic [CW-1:0] cnt [4];

  assign btn_raw = {btn_go, btn_op, btn_b, btn_a};
  assign press   = level & ~level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_d <= level;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != level[i]) begin
          if (cnt[i] == CNT_LAST) begin
            level[i] <= sync2[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Payload is only editable in ENTRY; presses arriving during ISSUE are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ENTRY;
      operand_a   <= 1'b0;
      operand_b   <= 1'b0;
      option      <= 2'd0;
      issue_valid <= 1'b0;
      issue_count <= 8'd0;
      busy        <= 1'b0;
    end else begin
      case (state)
        ENTRY: begin
          if (press[0]) operand_a <= ~operand_a;
          if (press[1]) operand_b <= ~operand_b;
          if (press[2]) option    <= option + 2'd1;
          if (press[3]) begin
            state       <= ISSUE;
            issue_valid <= 1'b1;
            busy        <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue_ready) begin
            state       <= ENTRY;
            issue_valid <= 1'b0;
            busy        <= 1'b0;
            issue_count <= issue_count + 8'd1;
          end
        end
        default: begin
          state       <= ENTRY;
          issue_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_entry.sv
// tb/tb_alu_operand_entry.sv - directed-vector bench for alu_operand_entry
module tb_alu_operand_entry;

  logic       clk;
  logic       rst_n;
  logic       btn_a;
  logic       btn_b;
  logic       btn_op;
  logic       btn_go;
  logic       operand_a;
  logic       operand_b;
  logic [1:0] option;
  logic       issue_valid;
  logic       issue_ready;
  logic [7:0] issue_count;
  logic       busy;

  int vectors;
  int miscompares;

  alu_operand_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_a       (btn_a),
    .btn_b       (btn_b),
    .btn_op      (btn_op),
    .btn_go      (btn_go),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .option      (option),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_count (issue_count),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      0: btn_a = v;
      1: btn_b = v;
      2: btn_op = v;
      default: btn_go = v;
    endcase
  endtask

  task automatic press_btn(input int idx, input int hold);
    set_btn(idx, 1'b1);
    repeat (hold) @(negedge clk);
    set_btn(idx, 1'b0);
    repeat (8) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {btn_a, btn_b, btn_op, btn_go, issue_ready} = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {btn_a, btn_b, btn_op, btn_go, issue_ready} = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({operand_a, operand_b, option, issue_valid, issue_count, busy} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_state: got %b expected all zero",
               {operand_a, operand_b, option, issue_valid, issue_count, busy});
    end
    rst_n = 1'b1;
    @(negedge clk);
    press_btn(3, 10);
    vectors++;
    if ({issue_valid, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL enter_issue: valid/busy got %b expected 11", {issue_valid, busy});
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({operand_a, operand_b, option, issue_valid, issue_count, busy} !== 14'd0) begin
      miscompares++;
      $display("FAIL async_reset_mid_issue: got %b expected all zero",
               {operand_a, operand_b, option, issue_valid, issue_count, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_press();
    btn_a = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      vectors++;
      if (operand_a !== (e >= 7)) begin
        miscompares++;
        $display("FAIL press_latency edge %0d: operand_a got %b expected %b", e, operand_a, (e >= 7));
      end
    end
    btn_a = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_bounce();
    apply_reset();
    repeat (5) begin
      btn_op = 1'b1;
      repeat (3) @(negedge clk);
      btn_op = 1'b0;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    vectors++;
    if (option !== 2'd0) begin
      miscompares++;
      $display("FAIL bounce_reject: option got %0d expected 0", option);
    end
    press_btn(2, 10);
    vectors++;
    if (option !== 2'd1) begin
      miscompares++;
      $display("FAIL clean_after_bounce: option got %0d expected 1", option);
    end
  endtask

  task automatic test_option_wrap();
    logic [1:0] expected [5];
    expected = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      press_btn(2, 10);
      vectors++;
      if (option !== expected[k]) begin
        miscompares++;
        $display("FAIL option_wrap press %0d: option got %0d expected %0d", k, option, expected[k]);
      end
    end
  endtask

  task automatic test_handshake();
    apply_reset();
    press_btn(0, 10);
    press_btn(2, 10);
    press_btn(2, 10);
    vectors++;
    if ({operand_a, operand_b, option} !== 4'b1010) begin
      miscompares++;
      $display("FAIL payload_setup: got %b expected 1010", {operand_a, operand_b, option});
    end
    press_btn(3, 10);
    for (int c = 0; c < 20; c++) begin
      btn_a  = (c < 8);
      btn_op = (c >= 8 && c < 16);
      @(negedge clk);
      vectors++;
      if ({issue_valid, busy, operand_a, operand_b, option} !== 6'b111010) begin
        miscompares++;
        $display("FAIL issue_hold cycle %0d: got %b expected 111010", c,
                 {issue_valid, busy, operand_a, operand_b, option});
      end
    end
    btn_a  = 1'b0;
    btn_op = 1'b0;
    repeat (8) @(negedge clk);
    issue_ready = 1'b1;
    @(negedge clk);
    issue_ready = 1'b0;
    vectors++;
    if ({issue_count, issue_valid, busy} !== {8'd1, 2'b00}) begin
      miscompares++;
      $display("FAIL transfer: count/valid/busy got %0d/%b/%b expected 1/0/0",
               issue_count, issue_valid, busy);
    end
    repeat (10) @(negedge clk);
    vectors++;
    if ({operand_a, operand_b, option, issue_count} !== {4'b1010, 8'd1}) begin
      miscompares++;
      $display("FAIL no_queued_press: payload %b count %0d expected 1010 count 1",
               {operand_a, operand_b, option}, issue_count);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    btn_b  = 1'b1;
    btn_go = 1'b1;
    repeat (10) @(negedge clk);
    btn_b  = 1'b0;
    btn_go = 1'b0;
    repeat (8) @(negedge clk);
    vectors++;
    if ({issue_valid, busy, operand_a, operand_b, option} !== 6'b110100) begin
      miscompares++;
      $display("FAIL simultaneous_b_go: got %b expected 110100",
               {issue_valid, busy, operand_a, operand_b, option});
    end
    issue_ready = 1'b1;
    @(negedge clk);
    issue_ready = 1'b0;
    vectors++;
    if ({issue_count, issue_valid} !== {8'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL simultaneous_transfer: count %0d valid %b expected 1/0", issue_count, issue_valid);
    end
  endtask

  task automatic test_count_wrap();
    int hi;
    apply_reset();
    issue_ready = 1'b1;
    for (int t = 0; t < 256; t++) begin
      hi = 0;
      btn_go = 1'b1;
      for (int c = 0; c < 18; c++) begin
        if (c == 8) btn_go = 1'b0;
        @(negedge clk);
        if (issue_valid === 1'b1) hi++;
      end
      vectors++;
      if (hi != 1) begin
        miscompares++;
        $display("FAIL valid_pulse txn %0d: high for %0d cycles expected 1", t, hi);
      end
      if (t == 254) begin
        vectors++;
        if (issue_count !== 8'd255) begin
          miscompares++;
          $display("FAIL count_255: got %0d expected 255", issue_count);
        end
      end
    end
    issue_ready = 1'b0;
    vectors++;
    if ({issue_count, issue_valid, busy} !== 10'd0) begin
      miscompares++;
      $display("FAIL count_wrap: count %0d valid %b busy %b expected 0/0/0",
               issue_count, issue_valid, busy);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single_press();
    test_bounce();
    test_option_wrap();
    test_handshake();
    test_simultaneous();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_operand_entry.md
# alu_operand_entry

Button front end for the iCEBreaker ALU demo: converts raw button levels into debounced, single-cycle press events. Presses edit a registered operand pair and a 2-bit operation select, which are then issued to the combinational ALU/LED stage over a valid/ready handshake. It replaces direct wiring of buttons to operand and option nets. Every value the ALU sees is stable, glitch-free and explicitly committed.

## Interface

Parameters:
- DEBOUNCE_CYCLES, default 240000 (20 ms at 12 MHz): consecutive cycles a synchronized input must differ from its debounced level before that level changes. Legal range is 1 and up.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset; asynchronous assert, active-low.
- btn_a  in  1  raw button, active-high (asynchronous); each press toggles operand_a.
- btn_b  in  1  raw button, active-high (asynchronous); each press toggles operand_b.
- btn_op  in  1  raw button, active-high (asynchronous); each press advances option.
- btn_go  in  1  raw button, active-high (asynchronous); each press commits and issues.
- operand_a  out  1  registered operand A.
- operand_b  out  1  registered operand B.
- option  out  2  registered operation select (0..3).
- issue_valid  out  1  payload (operand_a, operand_b, option) is offered downstream.
- issue_ready  in  1  downstream accepts the payload.
- issue_count  out  8  number of accepted issues, modulo 256.
- busy  out  1  high while in ISSUE state.

## Operation

- Each btn_* passes through a 2-flop synchronizer and then a per-button debouncer with its own counter.
- Debouncer behaviour:
  - If the synchronized value differs from the debounced level, the counter increments.
  - When the count reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the synchronized value and the counter clears.
  - Any cycle where the synchronized value equals the debounced level clears the counter. Bounces shorter than DEBOUNCE_CYCLES are therefore discarded.
- press_x is a one-cycle pulse, defined as the debounced level AND NOT its one-cycle-delayed copy. Releases generate no event.
- State ENTRY:
  - press_a toggles operand_a.
  - press_b toggles operand_b.
  - press_op sets option to option+1 modulo 4, so 3 wraps to 0.
  - press_go moves the state to ISSUE.
  - Presses in the same cycle all apply. Edits coinciding with press_go are applied, and the issued payload includes them.
- State ISSUE:
  - busy=1 and issue_valid=1.
  - The payload registers are frozen; presses on any button are dropped (not queued).
  - On the first edge with issue_ready=1, issue_count increments (255 wraps to 0) and the state returns to ENTRY.
- Only two states exist: ENTRY and ISSUE. There are no illegal encodings; an unused encoding, if any, recovers to ENTRY.
- Reset, asynchronous and allowed mid-operation:
  - state=ENTRY; operand_a=0, operand_b=0, option=0.
  - issue_valid=0, busy=0, issue_count=0.
  - Synchronizers, debounced levels, delayed copies and counters all = 0.
  - An in-flight issue is abandoned without incrementing the count.
- A button held through reset release is seen as a press once it is debounced.

## Timing

- Press latency: raw input stable high from the edge that first samples it (edge 1) takes:
  - 2 edges for the synchronizer;
  - then DEBOUNCE_CYCLES edges until the debounced level rises;
  - then the next edge updates the payload or state.
  - Total: DEBOUNCE_CYCLES+3 edges.
- issue_valid rises on the same edge that changes the state to ENTRY→ISSUE.
- issue_valid may rise without waiting for issue_ready. The payload and issue_valid are held until acceptance.
- Transfer occurs at an edge where issue_valid=1 and issue_ready=1. issue_valid is low in the following cycle, so it never stays high for back-to-back transfers.
- issue_ready asserted while in ENTRY has no effect.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan

All scenarios use DEBOUNCE_CYCLES=4.
- Reset and single press:
  - Assert rst_n=0 mid-ISSUE → all outputs 0 immediately, with no clock needed.
  - Release reset, then hold btn_a high for 10 cycles → operand_a=1 exactly 7 edges after first sample; no further toggle while held.
- Bounce rejection: btn_op pulsing high 3 cycles, low 1, repeated 5 times, then low → option stays 0. Then a 10-cycle clean press → option=1.
- Option wrap: 5 clean btn_op presses → option sequence 1,2,3,0,1.
- Handshake:
  - Set a=1, b=0, option=2, then press btn_go with issue_ready=0 → issue_valid=1, busy=1, payload 1/0/2 held for 20 cycles.
  - Presses of btn_a and btn_op during that window → payload unchanged.
  - Raise issue_ready → one transfer, issue_count=1, issue_valid=0 on the next cycle.
- Simultaneous events: btn_b and btn_go debounced on the same cycle → ISSUE entered with operand_b=1 in the payload.
- Count wrap: 256 go/ready transactions with issue_ready tied high → issue_count ends at 0, each issue_valid pulse lasting exactly 1 cycle.
